// File: rtl/pe_seq_ctrl.sv
// Command sequencer that drives one 16-lane PE through load/compute/feedback/capture/route phases.
// Optional PE_SEQ_CYCCNT_EN adds a saturating accept-to-result cycle counter on res_cycles.
module pe_seq_ctrl #(
    parameter int CU_LAT = 1,
    parameter int LOOP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [LOOP_W-1:0] cmd_loop,
    input  logic              cmd_fb,
    input  logic              cmd_dest,
    input  logic [511:0]      cmd_in,
    input  logic [511:0]      cmd_par,
    output logic [511:0]      pe_in,
    output logic [511:0]      pe_par,
    output logic [1:0]        sel_cu,
    output logic [1:0]        sel_cu_go_back,
    output logic [1:0]        sel_adder,
    output logic              is_save_cu_out,
    input  logic [31:0]       pe_out_total,
    input  logic [511:0]      pe_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [31:0]       res_total,
`ifdef PE_SEQ_CYCCNT_EN
    output logic [15:0]       res_cycles,
`endif
    output logic [511:0]      res_lanes
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_COMPUTE, S_FEEDBACK, S_CAPTURE, S_ROUTE, S_SETTLE, S_RESP
    } state_t;

    localparam logic [3:0] CU_LAST = 4'(CU_LAT - 1);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [LOOP_W-1:0] loop_q;
    logic              fb_q, dest_q;
    logic [1:0]        sel_cu_q, go_back_q, adder_q;
    logic              save_q, cmd_ready_q, res_valid_q;
    logic [511:0]      pe_in_q, pe_par_q, res_lanes_q;
    logic [31:0]       res_total_q;
`ifdef PE_SEQ_CYCCNT_EN
    logic [15:0]       cyc_q;
`endif

    // NOTE: all state here uses <= so every register samples pre-edge values; the
    // defaults at the top make go-back/adder/save one-cycle pulses without a latch risk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            loop_q      <= '0;
            fb_q        <= 1'b0;
            dest_q      <= 1'b0;
            sel_cu_q    <= 2'b00;
            go_back_q   <= 2'b00;
            adder_q     <= 2'b00;
            save_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            pe_in_q     <= '0;
            pe_par_q    <= '0;
            res_total_q <= '0;
            res_lanes_q <= '0;
`ifdef PE_SEQ_CYCCNT_EN
            cyc_q       <= '0;
`endif
        end else begin
            go_back_q <= 2'b00;
            adder_q   <= 2'b00;
            save_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        sel_cu_q    <= cmd_op;
                        loop_q      <= cmd_loop;
                        fb_q        <= cmd_fb;
                        dest_q      <= cmd_dest;
                        pe_in_q     <= cmd_in;
                        pe_par_q    <= cmd_par;
                        cmd_ready_q <= 1'b0;
                        state_q     <= S_LOAD;
`ifdef PE_SEQ_CYCCNT_EN
                        cyc_q       <= '0;
`endif
                    end
                end
                S_LOAD: begin
                    cnt_q   <= CU_LAST;
                    state_q <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (loop_q != '0) begin
                        save_q    <= 1'b1;
                        go_back_q <= fb_q ? 2'b01 : 2'b11;
                        state_q   <= S_FEEDBACK;
                    end else begin
                        go_back_q <= 2'b10;
                        state_q   <= S_CAPTURE;
                    end
                end
                S_FEEDBACK: begin
                    loop_q  <= loop_q - 1'b1;
                    cnt_q   <= CU_LAST;
                    state_q <= S_COMPUTE;
                end
                S_CAPTURE: begin
                    adder_q <= dest_q ? 2'b10 : 2'b01;
                    state_q <= S_ROUTE;
                end
                S_ROUTE: state_q <= S_SETTLE;
                S_SETTLE: begin
                    // PE output registers settle one cycle after routing; sample only here.
                    res_total_q <= dest_q ? pe_out_total : 32'd0;
                    res_lanes_q <= dest_q ? 512'd0 : pe_out;
                    res_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        sel_cu_q    <= 2'b00;
                        pe_in_q     <= '0;
                        pe_par_q    <= '0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
`ifdef PE_SEQ_CYCCNT_EN
            if (state_q != S_IDLE && state_q != S_RESP && cyc_q != 16'hFFFF)
                cyc_q <= cyc_q + 16'd1;
`endif
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign pe_in          = pe_in_q;
    assign pe_par         = pe_par_q;
    assign sel_cu         = sel_cu_q;
    assign sel_cu_go_back = go_back_q;
    assign sel_adder      = adder_q;
    assign is_save_cu_out = save_q;
    assign res_valid      = res_valid_q;
    assign res_total      = res_total_q;
    assign res_lanes      = res_lanes_q;
`ifdef PE_SEQ_CYCCNT_EN
    assign res_cycles     = cyc_q;
`endif

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Bench for pe_seq_ctrl: two instances (CU_LAT=1 and 3), a phase-schedule model derived from
// the latency arithmetic, a per-cycle compare process and literal expectations per scenario.
module tb_pe_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         cmd_valid_v [2];
    logic         res_ready_v [2];
    logic [1:0]   cmd_op;
    logic [3:0]   cmd_loop;
    logic         cmd_fb, cmd_dest;
    logic [511:0] cmd_in, cmd_par, pe_out;
    logic [31:0]  pe_out_total;

    logic         cmd_ready_w [2];
    logic [511:0] pe_in_w [2], pe_par_w [2], res_lanes_w [2];
    logic [1:0]   sel_cu_w [2], go_back_w [2], adder_w [2];
    logic         save_w [2], res_valid_w [2];
    logic [31:0]  res_total_w [2];
`ifdef PE_SEQ_CYCCNT_EN
    logic [15:0]  res_cycles_w [2];
`endif

    for (genvar g = 0; g < 2; g++) begin : g_dut
        pe_seq_ctrl #(.CU_LAT(g == 0 ? 1 : 3), .LOOP_W(4)) u_dut (
            .clk(clk), .rst(rst),
            .cmd_valid(cmd_valid_v[g]), .cmd_ready(cmd_ready_w[g]),
            .cmd_op(cmd_op), .cmd_loop(cmd_loop), .cmd_fb(cmd_fb), .cmd_dest(cmd_dest),
            .cmd_in(cmd_in), .cmd_par(cmd_par),
            .pe_in(pe_in_w[g]), .pe_par(pe_par_w[g]),
            .sel_cu(sel_cu_w[g]), .sel_cu_go_back(go_back_w[g]), .sel_adder(adder_w[g]),
            .is_save_cu_out(save_w[g]),
            .pe_out_total(pe_out_total), .pe_out(pe_out),
            .res_valid(res_valid_w[g]), .res_ready(res_ready_v[g]),
            .res_total(res_total_w[g]),
`ifdef PE_SEQ_CYCCNT_EN
            .res_cycles(res_cycles_w[g]),
`endif
            .res_lanes(res_lanes_w[g])
        );
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model of the command in flight; k counts edges since the accept edge.
    bit           m_active = 1'b0;
    int           m_d, m_k, m_cu, m_loop, m_total;
    logic [1:0]   m_op;
    bit           m_fb, m_dest;
    logic [511:0] m_in, m_par, m_lanes;
    logic [31:0]  m_tot;
    int           first_rv, save_cnt, save01_cnt, cap_cnt, add_cnt;
    int           fb_k [$];
    logic [31:0]  snap_total;
    logic [511:0] snap_lanes;
    logic [15:0]  snap_cyc;

    always @(negedge clk) begin
        if (m_active) begin
            automatic int   k    = m_k;
            automatic int   d    = m_d;
            automatic bit   fbk  = (k > 0) && (k % (m_cu + 1) == 0) && (k / (m_cu + 1) <= m_loop);
            automatic bit   cap  = (k == m_total - 3);
            automatic bit   rte  = (k == m_total - 2);
            automatic bit   resp = (k >= m_total);
            automatic logic [1:0] e_gb = fbk ? (m_fb ? 2'b01 : 2'b11) : (cap ? 2'b10 : 2'b00);
            automatic logic [1:0] e_ad = rte ? (m_dest ? 2'b10 : 2'b01) : 2'b00;
            check("cyc_cmd_ready", cmd_ready_w[d], 0);
            check("cyc_pe_in", pe_in_w[d], m_in);
            check("cyc_pe_par", pe_par_w[d], m_par);
            check("cyc_sel_cu", sel_cu_w[d], m_op);
            check("cyc_go_back", go_back_w[d], e_gb);
            check("cyc_save", save_w[d], fbk);
            check("cyc_sel_adder", adder_w[d], e_ad);
            check("cyc_res_valid", res_valid_w[d], resp);
            if (resp) begin
                check("cyc_res_total", res_total_w[d], m_dest ? m_tot : 32'd0);
                check("cyc_res_lanes", res_lanes_w[d], m_dest ? 512'd0 : m_lanes);
                snap_total = res_total_w[d];
                snap_lanes = res_lanes_w[d];
`ifdef PE_SEQ_CYCCNT_EN
                check("cyc_res_cycles", res_cycles_w[d], (m_total > 65535) ? 65535 : m_total);
                snap_cyc = res_cycles_w[d];
`endif
            end
            if (res_valid_w[d] && first_rv < 0) first_rv = k;
            if (save_w[d]) begin
                save_cnt++;
                if (go_back_w[d] == 2'b01) save01_cnt++;
                fb_k.push_back(k);
            end
            if (go_back_w[d] == 2'b10) cap_cnt++;
            if (adder_w[d] != 2'b00) add_cnt++;
            // The stub presents the real result only during SETTLE, inverted otherwise.
            pe_out_total = (k == m_total - 1) ? m_tot : ~m_tot;
            pe_out       = (k == m_total - 1) ? m_lanes : ~m_lanes;
            m_k++;
        end
    end

    task automatic check_reset(input int d);
        check("rst_cmd_ready", cmd_ready_w[d], 1);
        check("rst_pe_in", pe_in_w[d], 0);
        check("rst_pe_par", pe_par_w[d], 0);
        check("rst_sel_cu", sel_cu_w[d], 0);
        check("rst_go_back", go_back_w[d], 0);
        check("rst_sel_adder", adder_w[d], 0);
        check("rst_save", save_w[d], 0);
        check("rst_res_valid", res_valid_w[d], 0);
        check("rst_res_total", res_total_w[d], 0);
        check("rst_res_lanes", res_lanes_w[d], 0);
`ifdef PE_SEQ_CYCCNT_EN
        check("rst_res_cycles", res_cycles_w[d], 0);
`endif
    endtask

    task automatic drive_cmd(input int d, input logic [1:0] op, input int loop, input bit fb,
                             input bit dest);
        @(negedge clk);
        cmd_op   = op;
        cmd_loop = 4'(loop);
        cmd_fb   = fb;
        cmd_dest = dest;
        for (int i = 0; i < 16; i++) begin
            cmd_in[32*i +: 32]  = $urandom;
            cmd_par[32*i +: 32] = $urandom;
        end
        cmd_valid_v[d] = 1'b1;
    endtask

    task automatic run_cmd(input int d, input logic [1:0] op, input int loop, input bit fb,
                           input bit dest, input logic [31:0] tot, input logic [511:0] lanes,
                           input int hold, input bit early_ready, input bit busy_valid);
        drive_cmd(d, op, loop, fb, dest);
        m_d = d; m_op = op; m_loop = loop; m_fb = fb; m_dest = dest;
        m_in = cmd_in; m_par = cmd_par; m_tot = tot; m_lanes = lanes;
        m_cu = (d == 0) ? 1 : 3;
        m_total = 4 + m_cu + loop * (m_cu + 1);
        first_rv = -1; save_cnt = 0; save01_cnt = 0; cap_cnt = 0; add_cnt = 0;
        fb_k.delete();
        @(posedge clk);
        #1;
        cmd_valid_v[d] = busy_valid;
        cmd_in  = ~cmd_in;
        cmd_par = ~cmd_par;
        cmd_op  = ~cmd_op;
        cmd_fb  = ~cmd_fb;
        m_k = 0;
        m_active = 1'b1;
        if (early_ready) res_ready_v[d] = 1'b1;
        repeat (m_total + hold) @(posedge clk);
        #1;
        cmd_valid_v[d] = 1'b0;
        res_ready_v[d] = 1'b1;
        @(posedge clk);
        #1;
        m_active = 1'b0;
        res_ready_v[d] = 1'b0;
        check("post_cmd_ready", cmd_ready_w[d], 1);
        check("post_res_valid", res_valid_w[d], 0);
        check("post_sel_cu", sel_cu_w[d], 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] idx_lanes;
        for (int i = 0; i < 16; i++) idx_lanes[32*i +: 32] = 32'(i);

        rst = 1'b0;
        cmd_valid_v = '{1'b0, 1'b0};
        res_ready_v = '{1'b0, 1'b0};
        cmd_op = '0; cmd_loop = '0; cmd_fb = 1'b0; cmd_dest = 1'b0;
        cmd_in = '0; cmd_par = '0; pe_out = '0; pe_out_total = '0;
        repeat (2) @(negedge clk);
        check_reset(0);
        check_reset(1);
        rst = 1'b1;

        // Abort in LOAD: reset low for three cycles, outputs back to reset values.
        drive_cmd(0, 2'b10, 2, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        cmd_valid_v[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset(0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check_reset(0);
        end
        @(negedge clk);
        rst = 1'b1;

        // Sum mode after the aborted command.
        run_cmd(0, 2'b01, 0, 1'b0, 1'b1, 32'h0000_0088, {16{32'hDEAD_BEEF}}, 0, 1'b0, 1'b0);
        check("sum_latency", first_rv, 5);
        check("sum_capture_pulses", cap_cnt, 1);
        check("sum_adder_pulses", add_cnt, 1);
        check("sum_res_total", snap_total, 32'h88);
        check("sum_res_lanes", snap_lanes, 0);
`ifdef PE_SEQ_CYCCNT_EN
        check("sum_res_cycles", snap_cyc, 5);
`endif

        // Lane mode, three Par-path feedback passes, res_ready held high early.
        run_cmd(0, 2'b10, 3, 1'b1, 1'b0, 32'h1234_5678, idx_lanes, 0, 1'b1, 1'b0);
        check("lane_save_pulses", save_cnt, 3);
        check("lane_save_par_code", save01_cnt, 3);
        check("lane_latency", first_rv, 11);
        check("lane_15", snap_lanes[511:480], 15);
        check("lane_3", snap_lanes[127:96], 3);
        check("lane_res_total", snap_total, 0);

        // Backpressure for six cycles with a competing command offered.
        run_cmd(0, 2'b11, 1, 1'b0, 1'b1, 32'hCAFE_0001, idx_lanes, 6, 1'b0, 1'b1);
        check("bp_latency", first_rv, 7);
        check("bp_res_total", snap_total, 32'hCAFE_0001);

        // In-path feedback on the CU_LAT=3 instance.
        run_cmd(1, 2'b01, 2, 1'b0, 1'b0, 32'h0BAD_F00D, idx_lanes, 1, 1'b0, 1'b0);
        check("inpath_pulses", fb_k.size(), 2);
        if (fb_k.size() == 2) begin
            check("inpath_first_pulse", fb_k[0], 4);
            check("inpath_second_pulse", fb_k[1], 8);
        end
        check("inpath_latency", first_rv, 15);
        check("inpath_lane_15", snap_lanes[511:480], 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
